// File: rtl/nvme_cmpl_arb_pkg.sv
// nvme_cmpl_pkg: shared FSM states, completion record type and tracker entry layout
package nvme_cmpl_pkg;

    localparam int ACTION_ID_W     = 4;
    localparam int SEQ_W           = 8;
    localparam int TRACK_VALID_BIT = 0;
    localparam int TRACK_ERR_BIT   = 1;

    typedef enum logic [2:0] {
        INIT,
        SCAN,
        REQ,
        WAIT,
        PUSH
    } state_t;

    typedef struct packed {
        logic [ACTION_ID_W-1:0] action_id;
        logic [SEQ_W-1:0]       seq;
        logic                   error;
    } cmpl_rec_t;

endpackage

// File: rtl/nvme_cmpl_arb_if.sv
// nvme_cmpl_arb_if: tracker, completion stream and error-flag signals of the completion arbiter
interface nvme_cmpl_arb_if #(
    parameter int ACTION_ID_BITS  = 4,
    parameter int TRACK_INFO_BITS = 2,
    parameter int TRACK_NUM       = 256
);

    localparam int ACTIONS  = 2**ACTION_ID_BITS;
    localparam int SEQ_BITS = $clog2(TRACK_NUM);

    logic                       track_init;
    logic [ACTIONS-1:0]         track_status;
    logic                       track_update;
    logic [ACTION_ID_BITS-1:0]  track_update_id;
    logic                       track_update_done;
    logic [TRACK_INFO_BITS-1:0] track_update_data;
    logic [ACTIONS-1:0]         action_enable;
    logic                       cmpl_valid;
    logic                       cmpl_ready;
    logic [ACTION_ID_BITS-1:0]  cmpl_action_id;
    logic [SEQ_BITS-1:0]        cmpl_seq;
    logic                       cmpl_error;
    logic                       arb_timeout;
    logic                       arb_spurious;
    logic                       err_clear;

    modport master (
        input  track_init, track_status, track_update_done, track_update_data,
               action_enable, cmpl_ready, err_clear,
        output track_update, track_update_id, cmpl_valid, cmpl_action_id,
               cmpl_seq, cmpl_error, arb_timeout, arb_spurious
    );

    modport slave (
        output track_init, track_status, track_update_done, track_update_data,
               action_enable, cmpl_ready, err_clear,
        input  track_update, track_update_id, cmpl_valid, cmpl_action_id,
               cmpl_seq, cmpl_error, arb_timeout, arb_spurious
    );

endinterface

// File: rtl/nvme_rr_pick.sv
// nvme_rr_pick: combinational pick of the first requesting ID at or after the round-robin pointer
module nvme_rr_pick #(
    parameter int ID_BITS = 4
) (
    input  logic [2**ID_BITS-1:0] req,
    input  logic [ID_BITS-1:0]    rr_ptr,
    output logic                  grant_valid,
    output logic [ID_BITS-1:0]    grant_id
);

    // walk offsets from farthest to nearest so the nearest requester is the one left standing
    always_comb begin
        grant_valid = 1'b0;
        grant_id    = '0;
        for (int i = 2**ID_BITS - 1; i >= 0; i--) begin
            if (req[rr_ptr + ID_BITS'(i)]) begin
                grant_valid = 1'b1;
                grant_id    = rr_ptr + ID_BITS'(i);
            end
        end
    end

endmodule

// File: rtl/nvme_cmpl_arb.sv
// nvme_cmpl_arb: round-robin pop of ready tracker entries into an in-order completion stream
module nvme_cmpl_arb
    import nvme_cmpl_pkg::*;
#(
    parameter int ACTION_ID_BITS  = ACTION_ID_W,
    parameter int TRACK_INFO_BITS = 2,
    parameter int TRACK_NUM       = 256,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input logic             axi_aclk,
    input logic             axi_areset,
    nvme_cmpl_arb_if.master bus
);

    localparam int ACTIONS  = 2**ACTION_ID_BITS;
    localparam int SEQ_BITS = $clog2(TRACK_NUM);
    localparam int TMO_BITS = $clog2(TIMEOUT_CYCLES);

    state_t                     state, state_nxt;
    logic [ACTIONS-1:0]         req;
    logic [ACTION_ID_BITS-1:0]  rr_ptr, upd_id, grant_id, next_ptr;
    logic [SEQ_BITS-1:0]        seq [ACTIONS];
    logic [TMO_BITS-1:0]        tmo_cnt;
    logic [TRACK_INFO_BITS-1:0] data;
    cmpl_rec_t                  rec;
    logic                       cmpl_valid, timeout, spurious;
    logic                       grant_valid, done_ok, done_bad, tmo_hit;

    assign req      = bus.track_status & bus.action_enable;
    assign data     = bus.track_update_data;
    assign done_ok  = state == WAIT && bus.track_update_done && data[TRACK_VALID_BIT];
    assign done_bad = state == WAIT && bus.track_update_done && !data[TRACK_VALID_BIT];
    assign tmo_hit  = state == WAIT && !bus.track_update_done && tmo_cnt == TMO_BITS'(TIMEOUT_CYCLES - 1);
    assign next_ptr = upd_id + 1'b1;

    nvme_rr_pick #(.ID_BITS(ACTION_ID_BITS)) u_pick (
        .req         (req),
        .rr_ptr      (rr_ptr),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    // next-state decode; a done in the same cycle as the timeout limit still counts as done
    always_comb begin
        state_nxt = state;
        case (state)
            INIT:    state_nxt = bus.track_init ? SCAN : INIT;
            SCAN:    state_nxt = grant_valid ? REQ : SCAN;
            REQ:     state_nxt = WAIT;
            WAIT:    state_nxt = done_ok ? PUSH : (done_bad || tmo_hit) ? SCAN : WAIT;
            PUSH:    state_nxt = bus.cmpl_ready ? SCAN : PUSH;
            default: state_nxt = INIT;
        endcase
    end

    // state, request ID, timeout counter, completion record, sequence counters and sticky flags
    always_ff @(posedge axi_aclk) begin
        if (axi_areset) begin
            state      <= INIT;
            rr_ptr     <= '0;
            upd_id     <= '0;
            tmo_cnt    <= '0;
            rec        <= '0;
            cmpl_valid <= 1'b0;
            timeout    <= 1'b0;
            spurious   <= 1'b0;
            for (int i = 0; i < ACTIONS; i++) seq[i] <= '0;
        end else begin
            state <= state_nxt;
            if (state == SCAN && grant_valid) upd_id <= grant_id;
            tmo_cnt <= state == REQ ? '0 : state == WAIT ? tmo_cnt + 1'b1 : tmo_cnt;
            if (done_ok) begin
                rec <= '{action_id: upd_id, seq: seq[upd_id], error: data[TRACK_ERR_BIT]};
                seq[upd_id] <= seq[upd_id] == SEQ_BITS'(TRACK_NUM - 1) ? '0 : seq[upd_id] + 1'b1;
            end
            if (done_ok || done_bad) rr_ptr <= next_ptr;
            cmpl_valid <= done_ok || (cmpl_valid && !bus.cmpl_ready);
            timeout    <= tmo_hit || (timeout && !bus.err_clear);
            spurious   <= done_bad || (spurious && !bus.err_clear);
        end
    end

    assign bus.track_update    = state == REQ;
    assign bus.track_update_id = upd_id;
    assign bus.cmpl_valid      = cmpl_valid;
    assign bus.cmpl_action_id  = rec.action_id;
    assign bus.cmpl_seq        = rec.seq;
    assign bus.cmpl_error      = rec.error;
    assign bus.arb_timeout     = timeout;
    assign bus.arb_spurious    = spurious;

endmodule

// File: tb/tb_nvme_cmpl_arb.sv
// tb_nvme_cmpl_arb: scoreboard bench driving a tracker model against the completion arbiter
module tb_nvme_cmpl_arb;

    typedef struct {
        logic [3:0] id;
        int         seq;
        logic       err;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    int   seq_m [16];
    exp_t q [$];
    logic [3:0] order [4] = '{4'd1, 4'd5, 4'd9, 4'd1};

    nvme_cmpl_arb_if bus ();

    nvme_cmpl_arb dut (
        .axi_aclk   (clk),
        .axi_areset (rst),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no end of run, required end before 1000000");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, required %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string pfx);
        check({pfx, "_update"},   bus.track_update, 0);
        check({pfx, "_update_id"}, bus.track_update_id, 0);
        check({pfx, "_valid"},    bus.cmpl_valid, 0);
        check({pfx, "_action"},   bus.cmpl_action_id, 0);
        check({pfx, "_seq"},      bus.cmpl_seq, 0);
        check({pfx, "_error"},    bus.cmpl_error, 0);
        check({pfx, "_timeout"},  bus.arb_timeout, 0);
        check({pfx, "_spurious"}, bus.arb_spurious, 0);
    endtask

    task automatic clear_model();
        q.delete();
        foreach (seq_m[i]) seq_m[i] = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_model();
        repeat (2) tick();
        check_idle("rst");
        rst = 1'b0;
    endtask

    task automatic wait_update(input logic [3:0] id);
        int n = 0;
        while (!bus.track_update && n < 64) begin
            tick();
            n++;
        end
        check("upd_seen", bus.track_update, 1);
        check("upd_id", bus.track_update_id, id);
    endtask

    // tracker model: answer the pop dly cycles into WAIT and record what the arbiter must emit
    task automatic serve(input logic [3:0] id, input int dly, input logic [1:0] data, input logic eclr);
        wait_update(id);
        tick();
        check("upd_pulse", bus.track_update, 0);
        repeat (dly - 1) begin
            check("upd_id_hold", bus.track_update_id, id);
            tick();
        end
        bus.track_update_done = 1'b1;
        bus.track_update_data = data;
        bus.err_clear         = eclr;
        if (data[0]) begin
            q.push_back('{id, seq_m[id], data[1]});
            seq_m[id] = (seq_m[id] + 1) % 256;
        end
        tick();
        bus.track_update_done = 1'b0;
        bus.track_update_data = 2'b00;
        bus.err_clear         = 1'b0;
        check("valid_lat", bus.cmpl_valid, data[0]);
    endtask

    task automatic take_cmpl();
        int   n = 0;
        exp_t e;
        while (!bus.cmpl_valid && n < 64) begin
            tick();
            n++;
        end
        check("cmpl_seen", bus.cmpl_valid, 1);
        check("sb_nonempty", q.size() != 0, 1);
        if (q.size() != 0) begin
            e = q.pop_front();
            check("cmpl_id", bus.cmpl_action_id, e.id);
            check("cmpl_seq", bus.cmpl_seq, e.seq);
            check("cmpl_err", bus.cmpl_error, e.err);
        end
        bus.cmpl_ready = 1'b1;
        tick();
        check("cmpl_drop", bus.cmpl_valid, 0);
    endtask

    initial begin
        int n;
        bus.track_init        = 1'b0;
        bus.track_status      = '0;
        bus.track_update_done = 1'b0;
        bus.track_update_data = 2'b00;
        bus.action_enable     = '1;
        bus.cmpl_ready        = 1'b1;
        bus.err_clear         = 1'b0;
        do_reset();

        bus.track_status = 16'h0004;
        repeat (3) begin
            tick();
            check("init_hold", bus.track_update, 0);
        end
        bus.track_init = 1'b1;
        serve(4'd2, 3, 2'b01, 1'b0);
        bus.track_status = '0;
        take_cmpl();

        do_reset();
        bus.track_status = 16'h0222;
        foreach (order[i]) begin
            serve(order[i], 1, 2'b01, 1'b0);
            take_cmpl();
        end
        bus.track_status = '0;

        bus.track_status = 16'h0008;
        bus.cmpl_ready   = 1'b0;
        serve(4'd3, 2, 2'b11, 1'b0);
        bus.track_status = '0;
        repeat (10) begin
            check("hold_valid", bus.cmpl_valid, 1);
            check("hold_id", bus.cmpl_action_id, 3);
            check("hold_seq", bus.cmpl_seq, 0);
            check("hold_err", bus.cmpl_error, 1);
            check("hold_noupd", bus.track_update, 0);
            tick();
        end
        take_cmpl();

        do_reset();
        bus.track_status  = 16'h0001;
        bus.action_enable = 16'h0001;
        repeat (257) begin
            serve(4'd0, 1, 2'b01, 1'b0);
            take_cmpl();
        end
        bus.track_status  = '0;
        bus.action_enable = '1;

        bus.track_status = 16'h0010;
        wait_update(4'd4);
        tick();
        n = 0;
        while (!bus.arb_timeout && n < 2000) begin
            tick();
            n++;
        end
        bus.track_status = '0;
        check("tmo_cycles", n, 1024);
        check("tmo_flag", bus.arb_timeout, 1);
        check("tmo_no_valid", bus.cmpl_valid, 0);
        tick();
        check("tmo_scan_idle", bus.track_update, 0);
        bus.err_clear = 1'b1;
        tick();
        bus.err_clear = 1'b0;
        check("tmo_clear", bus.arb_timeout, 0);
        bus.track_status = 16'h0040;
        serve(4'd6, 2, 2'b01, 1'b0);
        take_cmpl();

        serve(4'd6, 1, 2'b00, 1'b1);
        check("spur_flag", bus.arb_spurious, 1);
        serve(4'd6, 1, 2'b01, 1'b0);
        take_cmpl();

        wait_update(4'd6);
        tick();
        rst = 1'b1;
        tick();
        check_idle("midrst");
        clear_model();
        rst = 1'b0;
        serve(4'd6, 1, 2'b01, 1'b0);
        take_cmpl();

        serve(4'd6, 1, 2'b00, 1'b0);
        bus.track_status = '0;
        check("spur_set", bus.arb_spurious, 1);
        bus.err_clear = 1'b1;
        tick();
        bus.err_clear = 1'b0;
        check("spur_clear", bus.arb_spurious, 0);
        check("sb_drained", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
